// File: rtl/uart_periph.sv
// 8N1 UART peripheral: transmitter, receiver with two-flop input synchronizer,
// and a receive-flag/interrupt pair that the CPU clears by reading address 252.
module uart_periph #(
  parameter int unsigned CLKS_PER_BIT = 347
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       tx_en,
  input  logic       rx_en,
  input  logic       begin_flag,
  input  logic [7:0] tx_data,
  input  logic       rx,
  input  logic [7:0] access_addr,
  input  logic       reg_w_en,
  output logic       tx,
  output logic [7:0] rx_data,
  output logic       busy_flag,
  output logic       receive_flag,
  output logic       int_req
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0]    RX_ADDR   = 8'd252;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // ---------------- transmitter ----------------
  tx_state_t     r_tx_state, w_tx_state_nxt;
  logic [CW-1:0] r_tx_cnt, w_tx_cnt_nxt;
  logic [2:0]    r_tx_idx, w_tx_idx_nxt;
  logic [7:0]    r_tx_data;
  logic          w_tx_load;
  logic          w_tx;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_data  <= '0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_idx   <= w_tx_idx_nxt;
      if (w_tx_load) r_tx_data <= tx_data;
    end
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_idx_nxt   = r_tx_idx;
    w_tx_load      = 1'b0;
    w_tx           = 1'b1;
    case (r_tx_state)
      TX_IDLE: begin
        if (begin_flag && tx_en) begin
          w_tx_state_nxt = TX_START;
          w_tx_cnt_nxt   = '0;
          w_tx_load      = 1'b1;
        end
      end
      TX_START: begin
        w_tx = 1'b0;
        if (r_tx_cnt == LAST) begin
          w_tx_cnt_nxt   = '0;
          w_tx_idx_nxt   = '0;
          w_tx_state_nxt = TX_DATA;
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + CW'(1);
        end
      end
      TX_DATA: begin
        w_tx = r_tx_data[r_tx_idx];
        if (r_tx_cnt == LAST) begin
          w_tx_cnt_nxt = '0;
          if (r_tx_idx == 3'd7) w_tx_state_nxt = TX_STOP;
          else                  w_tx_idx_nxt   = r_tx_idx + 3'd1;
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + CW'(1);
        end
      end
      TX_STOP: begin
        if (r_tx_cnt == LAST) begin
          w_tx_cnt_nxt   = '0;
          w_tx_state_nxt = TX_IDLE;
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + CW'(1);
        end
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  assign tx        = w_tx;
  assign busy_flag = (r_tx_state != TX_IDLE);

  // ---------------- receiver ----------------
  // s3 holds the previous synchronized sample; all three reset high so that
  // leaving reset can never look like a falling edge.
  logic          r_rx_s1, r_rx_s2, r_rx_s3;
  rx_state_t     r_rx_state, w_rx_state_nxt;
  logic [CW-1:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]    r_rx_idx, w_rx_idx_nxt;
  logic [7:0]    r_rx_shift;
  logic [7:0]    r_rx_data;
  logic          r_rx_flag, r_int_req;
  logic          w_rx_shift_en, w_rx_done, w_rx_fall, w_rd_strobe;

  assign w_rx_fall   = r_rx_s3 & ~r_rx_s2;
  assign w_rd_strobe = reg_w_en && (access_addr == RX_ADDR);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_s3    <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_flag  <= 1'b0;
      r_int_req  <= 1'b0;
    end else begin
      r_rx_s1    <= rx;
      r_rx_s2    <= r_rx_s1;
      r_rx_s3    <= r_rx_s2;
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_idx   <= w_rx_idx_nxt;
      if (w_rx_shift_en) r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
      // A completed byte takes priority over a same-cycle CPU read.
      if (w_rx_done) begin
        r_rx_data <= r_rx_shift;
        r_rx_flag <= 1'b1;
        r_int_req <= 1'b1;
      end else if (w_rd_strobe) begin
        r_rx_flag <= 1'b0;
        r_int_req <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_idx_nxt   = r_rx_idx;
    w_rx_shift_en  = 1'b0;
    w_rx_done      = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (w_rx_fall) begin
          w_rx_state_nxt = RX_START;
          w_rx_cnt_nxt   = '0;
        end
      end
      RX_START: begin
        if (r_rx_cnt == HALF_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_idx_nxt   = '0;
          w_rx_state_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + CW'(1);
        end
      end
      RX_DATA: begin
        if (r_rx_cnt == LAST) begin
          w_rx_cnt_nxt  = '0;
          w_rx_shift_en = 1'b1;
          if (r_rx_idx == 3'd7) w_rx_state_nxt = RX_STOP;
          else                  w_rx_idx_nxt   = r_rx_idx + 3'd1;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + CW'(1);
        end
      end
      RX_STOP: begin
        if (r_rx_cnt == LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_state_nxt = RX_IDLE;
          w_rx_done      = r_rx_s2;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + CW'(1);
        end
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
    if (!rx_en) begin
      w_rx_state_nxt = RX_IDLE;
      w_rx_cnt_nxt   = '0;
      w_rx_idx_nxt   = '0;
      w_rx_shift_en  = 1'b0;
      w_rx_done      = 1'b0;
    end
  end

  assign rx_data      = r_rx_data;
  assign receive_flag = r_rx_flag;
  assign int_req      = r_int_req;

endmodule
